frame_tx: RTL and testbench

FRAME_TX -- requirements
Module: frame_tx

---
 rtl/frame_tx.sv | 156 +++++++++++++++
 tb/tb_frame_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/frame_tx.sv
// frame_tx: UART 8N1 transmitter for a HEADER / score / 16-byte dot-matrix frame.
// Optional macro FRAME_TX_CHECKSUM_EN appends an XOR checksum byte (20 bytes instead of 19).
module frame_tx #(
  parameter int          CLK_PER_BIT = 5208,
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [15:0]  i_score,
  input  logic [127:0] i_dot,
  output logic         o_tx,
  output logic         o_busy,
  output logic         o_done
);

  localparam int             CW      = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(CLK_PER_BIT - 1);
`ifdef FRAME_TX_CHECKSUM_EN
  localparam int             N_BYTES = 20;
`else
  localparam int             N_BYTES = 19;
`endif
  localparam logic [4:0]     LAST_BYTE = 5'(N_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_bitIdx;
  logic [4:0]     r_byteIdx;
  logic [7:0]     r_shift;
  logic [15:0]    r_score;
  logic [127:0]   r_dot;
  logic           r_tx;
  logic           r_busy;
  logic           r_done;

  logic           w_bitEnd;
  logic [4:0]     w_nextIdx;
  logic [7:0]     w_nextByte;

  assign w_bitEnd  = (r_cnt == CNT_MAX);
  assign w_nextIdx = r_byteIdx + 5'd1;

`ifdef FRAME_TX_CHECKSUM_EN
  logic [7:0] w_checksum;

  // XOR of every payload byte; HEADER is deliberately excluded.
  always_comb begin
    w_checksum = r_score[15:8] ^ r_score[7:0];
    for (int k = 0; k < 16; k++) begin
      w_checksum = w_checksum ^ r_dot[8*k +: 8];
    end
  end
`endif

  // Byte loaded at the end of a stop bit; HEADER is loaded directly on acceptance.
  always_comb begin
    w_nextByte = 8'h00;
    case (w_nextIdx)
      5'd1:    w_nextByte = r_score[15:8];
      5'd2:    w_nextByte = r_score[7:0];
`ifdef FRAME_TX_CHECKSUM_EN
      5'd19:   w_nextByte = w_checksum;
`endif
      default: w_nextByte = 8'h00;
    endcase
    for (int k = 0; k < 16; k++) begin
      if (w_nextIdx == 5'(k + 3)) begin
        w_nextByte = r_dot[127 - 8*k -: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bitIdx  <= '0;
      r_byteIdx <= '0;
      r_shift   <= '0;
      r_score   <= '0;
      r_dot     <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (i_start) begin
            r_score   <= i_score;
            r_dot     <= i_dot;
            r_shift   <= HEADER;
            r_byteIdx <= '0;
            r_cnt     <= '0;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= START;
          end
        end
        START: begin
          if (w_bitEnd) begin
            r_cnt    <= '0;
            r_bitIdx <= '0;
            r_tx     <= r_shift[0];
            r_state  <= DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DATA: begin
          if (w_bitEnd) begin
            r_cnt <= '0;
            if (r_bitIdx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
              r_shift  <= {1'b0, r_shift[7:1]};
              r_tx     <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        STOP: begin
          // Back-to-back bytes: the next start bit directly follows this stop bit.
          if (w_bitEnd) begin
            r_cnt <= '0;
            if (r_byteIdx == LAST_BYTE) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_byteIdx <= w_nextIdx;
              r_shift   <= w_nextByte;
              r_tx      <= 1'b0;
              r_state   <= START;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_tx   = r_tx;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_frame_tx.sv
// tb_frame_tx: table-driven self-checking bench for frame_tx with CLK_PER_BIT=4.
// Follows FRAME_TX_CHECKSUM_EN to decide whether the checksum byte is expected.
module tb_frame_tx;

  localparam int CPB = 4;
`ifdef FRAME_TX_CHECKSUM_EN
  localparam int NB = 20;
`else
  localparam int NB = 19;
`endif
  localparam int FRAME_CYC = NB * 10 * CPB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_start = 1'b0;
  logic [15:0]  i_score = '0;
  logic [127:0] i_dot = '0;
  logic         o_tx;
  logic         o_busy;
  logic         o_done;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [15:0]  score;
    logic [127:0] dot;
    logic [7:0]   check;
  } vec_t;

  vec_t vecs[4];

  frame_tx #(.CLK_PER_BIT(CPB), .HEADER(8'hA5)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_score (i_score),
    .i_dot   (i_dot),
    .o_tx    (o_tx),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] expByte(input logic [15:0] s, input logic [127:0] d,
                                         input logic [7:0] chk, input int j);
    if (j == 0)       return 8'hA5;
    else if (j == 1)  return s[15:8];
    else if (j == 2)  return s[7:0];
    else if (j <= 18) return d[127 - 8*(j-3) -: 8];
    else              return chk;
  endfunction

  // Called just after a falling edge; the next rising edge accepts the frame.
  task automatic applyStimulus(input logic [15:0] s, input logic [127:0] d);
    i_score = s;
    i_dot   = d;
    i_start = 1'b1;
  endtask

  task automatic checkIdle(input int n, input string tag);
    bit bad = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) bad = 1'b1;
    end
    checkOutput({tag, " idle"}, 32'(bad), 32'd0);
  endtask

  // Decodes one frame sampling mid-bit; t=0 is the first start-bit cycle.
  task automatic captureFrame(input logic [15:0] s, input logic [127:0] d, input logic [7:0] chk,
                              input bit keepStart, input bit disturb, input string tag);
    logic [7:0] rx[NB];
    int doneAt    = -1;
    int doneCount = 0;
    bit frameErr  = 1'b0;
    bit busyErr   = 1'b0;
    for (int j = 0; j < NB; j++) rx[j] = 8'h00;
    for (int t = 0; t <= FRAME_CYC; t++) begin
      @(negedge clk);
      if (t == 0) begin
        checkOutput({tag, " first-cycle tx"}, 32'(o_tx), 32'd0);
        checkOutput({tag, " first-cycle busy"}, 32'(o_busy), 32'd1);
        if (!keepStart) i_start = 1'b0;
      end
      if (disturb && t == 100) begin
        i_score = ~s;
        i_dot   = ~d;
        i_start = 1'b1;
      end
      if (disturb && t == 108) i_start = 1'b0;
      if (o_done === 1'b1) begin
        doneCount++;
        if (doneAt < 0) doneAt = t;
      end
      if (t < FRAME_CYC) begin
        if (o_busy !== 1'b1) busyErr = 1'b1;
        if (t % CPB == CPB / 2) begin
          int bp = t / CPB;
          int bi = bp / 10;
          int b  = bp % 10;
          if (b == 0) begin
            if (o_tx !== 1'b0) frameErr = 1'b1;
          end else if (b == 9) begin
            if (o_tx !== 1'b1) frameErr = 1'b1;
          end else begin
            rx[bi][b-1] = o_tx;
          end
        end
      end else begin
        checkOutput({tag, " end busy"}, 32'(o_busy), 32'd0);
        checkOutput({tag, " end tx"}, 32'(o_tx), 32'd1);
      end
    end
    checkOutput({tag, " done cycle"}, 32'(doneAt), 32'(FRAME_CYC));
    checkOutput({tag, " done count"}, 32'(doneCount), 32'd1);
    checkOutput({tag, " framing"}, 32'(frameErr), 32'd0);
    checkOutput({tag, " busy held"}, 32'(busyErr), 32'd0);
    for (int j = 0; j < NB; j++) begin
      checkOutput($sformatf("%s byte %0d", tag, j), 32'(rx[j]), 32'(expByte(s, d, chk, j)));
    end
  endtask

  initial begin
    bit doneSeen;

    vecs[0] = '{16'h0123, 128'h0, 8'h22};
    vecs[1] = '{16'hFFFF, {128{1'b1}}, 8'h00};
    vecs[2] = '{16'hA55A, {16{8'h01}}, 8'hFF};
    vecs[3] = '{16'h0000, 128'h0102030405060708090A0B0C0D0E0F10, 8'h10};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset tx", 32'(o_tx), 32'd1);
    checkOutput("reset busy", 32'(o_busy), 32'd0);
    checkOutput("reset done", 32'(o_done), 32'd0);
    rst = 1'b0;
    checkIdle(100, "post-reset");

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].score, vecs[i].dot);
      captureFrame(vecs[i].score, vecs[i].dot, vecs[i].check, 1'b0, 1'b0, $sformatf("vec%0d", i));
      checkIdle(5, $sformatf("vec%0d after", i));
    end

    // Inputs change and i_start pulses mid-frame: contents fixed, nothing queued.
    @(negedge clk);
    applyStimulus(vecs[0].score, vecs[0].dot);
    captureFrame(vecs[0].score, vecs[0].dot, vecs[0].check, 1'b0, 1'b1, "disturb");
    checkIdle(50, "disturb no-requeue");

    // i_start held high: second frame starts right after the o_done cycle.
    @(negedge clk);
    applyStimulus(vecs[2].score, vecs[2].dot);
    captureFrame(vecs[2].score, vecs[2].dot, vecs[2].check, 1'b1, 1'b0, "held1");
    captureFrame(vecs[2].score, vecs[2].dot, vecs[2].check, 1'b0, 1'b0, "held2");
    checkIdle(20, "held after");

    // Asynchronous reset during the start bit of byte 5.
    @(negedge clk);
    applyStimulus(vecs[3].score, vecs[3].dot);
    doneSeen = 1'b0;
    for (int t = 0; t <= 201; t++) begin
      @(negedge clk);
      if (t == 0) i_start = 1'b0;
      if (o_done === 1'b1) doneSeen = 1'b1;
    end
    checkOutput("byte5 start bit", 32'(o_tx), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("async reset tx", 32'(o_tx), 32'd1);
    checkOutput("async reset busy", 32'(o_busy), 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (o_done === 1'b1) doneSeen = 1'b1;
    end
    rst = 1'b0;
    checkOutput("abort no done", 32'(doneSeen), 32'd0);
    checkIdle(10, "after abort");
    @(negedge clk);
    applyStimulus(vecs[1].score, vecs[1].dot);
    captureFrame(vecs[1].score, vecs[1].dot, vecs[1].check, 1'b0, 1'b0, "post-abort");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
